sqrt_arbiter: RTL
=================

Name: sqrt_arbiter

Overview:
- Round-robin scheduler that shares one sqrt unit (8-bit operand in, 8-bit result, busy flag, enable) among N_REQ requesters.
- Accepts operands over per-requester valid/ready, launches the sqrt and gates it via its enable, captures the result when busy falls, and returns it to the owning requester over a per-requester valid/ready response channel.
- Sits between the sqrt unit and the client logic, in the same clock domain.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(N_REQ), width of grant index
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset; one clock, reset asynchronous active-low
- req_valid_i  in  N_REQ  operand valid, one bit per requester
- req_data_i  in  8*N_REQ  operands; requester k uses bits [8k+7:8k]
- req_ready_o  out  N_REQ  operand accept, at most one bit high
- rsp_valid_o  out  N_REQ  result valid, one-hot or zero
- rsp_data_o  out  8  result, shared by all requesters
- rsp_err_o  out  1  result aborted by watchdog; qualifies rsp_valid_o
- rsp_ready_i  in  N_REQ  result accept, per requester
- sq_enb_o  out  1  sqrt enable / clock gate
- sq_dt_o  out  8  sqrt operand
- sq_busy_i  in  1  sqrt busy
- sq_dt_i  in  8  sqrt result
- grant_id_o  out  ID_W  index of current owner; valid outside IDLE

Behaviour:
- Reset (async, immediate):
  - All outputs 0; FSM to IDLE.
  - Round-robin pointer last_id = N_REQ-1, so requester 0 has first priority.
  - Result and operand registers cleared.
- State IDLE:
  - sq_enb_o=0.
  - If any req_valid_i: winner = first set bit searching from last_id+1 with wrap; req_ready_o[winner]=1 combinationally in the same cycle.
  - Latch req_data_i slice and winner id; go to LAUNCH.
  - No valid: stay.
- State LAUNCH:
  - sq_enb_o=1, sq_dt_o=latched operand.
  - Stay until sq_busy_i=1, then go to RUN.
- State RUN:
  - sq_enb_o=1, sq_dt_o held.
  - When sq_busy_i=0: register sq_dt_i into rsp_data_o; go to RESP.
- State RESP:
  - sq_enb_o=0 (sqrt frozen).
  - rsp_valid_o[grant]=1; rsp_data_o and rsp_err_o held stable.
  - When rsp_ready_i[grant]=1: last_id=grant, go to IDLE.
  - rsp_ready_i bits of non-owners are ignored.
- Latency:
  - Accept cycle t; LAUNCH at t+1; RESP one cycle after busy falls.
  - One bubble cycle in IDLE after every response; no back-to-back grant in the response-handshake cycle.
- Handshake rules:
  - Requesters must hold valid/data until ready; arbitration is re-evaluated each IDLE cycle.
  - Withdrawing valid before ready is legal; that requester is simply not granted.
- Boundaries:
  - Single outstanding operation; other requests wait with ready low.
  - Owner raising req_valid_i again during LAUNCH/RUN/RESP: not granted until the next IDLE.
  - Pointer wraps N_REQ-1 -> 0.
  - Async reset mid-LAUNCH/RUN/RESP drops sq_enb_o and rsp_valid_o immediately; the in-flight result is discarded.
  - sq_busy_i glitching high in IDLE or RESP is ignored.
  - grant_id_o holds the last owner while in IDLE.

Optional Feature:
- Macro SQRT_ARB_TIMEOUT_EN.
- Defined:
  - Cycle counter, cleared on entering LAUNCH, increments in LAUNCH and RUN.
  - On reaching TIMEOUT_CYC: go to RESP with rsp_data_o=0 and rsp_err_o=1.
  - rsp_err_o cleared on the response handshake.
- Not defined:
  - No counter; LAUNCH/RUN wait indefinitely.
  - rsp_err_o tied 0; port list unchanged.

Test Plan:
- After reset, req_valid_i=0001, data0=144, sqrt model attached -> req_ready_o=0001 for one cycle; sq_dt_o=144 with sq_enb_o=1; rsp_valid_o=0001, rsp_data_o=12, rsp_err_o=0.
- All four valid at once after reset, data 0, 1, 4, 81, rsp_ready_i=1111 -> grants and responses in order 0,1,2,3 with results 0,1,2,9; exactly one response per requester.
- Requesters 1 and 3 continuously valid (data 49, 225) -> grant sequence 1,3,1,3; results alternate 7,15; grant_id_o matches.
- Result ready, rsp_ready_i held 0 for 20 cycles -> rsp_valid_o and rsp_data_o stable, sq_enb_o=0, all req_ready_o=0; release -> IDLE next cycle, new grant the cycle after.
- rstn_i pulsed low during RUN of requester 2 -> outputs 0 immediately, no response issued; next simultaneous requests 2 and 0 grant 0 first.
- With SQRT_ARB_TIMEOUT_EN, TIMEOUT_CYC=64, sq_busy_i stuck 1 -> RESP entered 64 cycles after LAUNCH; rsp_err_o=1, rsp_data_o=0; rsp_err_o cleared after handshake.

Source files
------------

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter
//   Round-robin scheduler that shares one iterative sqrt unit among N_REQ
//   requesters. It takes one operand at a time, drives the sqrt unit until
//   busy falls, then returns the registered result to the requester that
//   owns the operation.
//
// Ports
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   req_valid_i/ready_o    per-requester operand handshake (ready at most one-hot)
//   req_data_i             8-bit operand per requester, packed [8k+7:8k]
//   rsp_valid_o/ready_i    per-requester result handshake (valid one-hot or zero)
//   rsp_data_o, rsp_err_o  shared result and watchdog-abort flag
//   sq_enb_o, sq_dt_o      sqrt unit enable (clock gate) and operand
//   sq_busy_i, sq_dt_i     sqrt unit busy flag and result
//   grant_id_o             index of the current/last owner
//
// Build option
//   SQRT_ARB_TIMEOUT_EN    adds a watchdog: if LAUNCH+RUN lasts TIMEOUT_CYC
//                          cycles the operation is returned with rsp_err_o=1
//                          and rsp_data_o=0. Without it rsp_err_o is tied low.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no operation; arbitrate and accept one operand
// S_LAUNCH | sqrt enabled with operand, waiting for busy to rise
// S_RUN    | sqrt computing, waiting for busy to fall
// S_RESP   | sqrt frozen, result offered to the owner

module sqrt_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = $clog2(N_REQ),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [N_REQ-1:0]     rsp_valid_o,
  output logic [7:0]           rsp_data_o,
  output logic                 rsp_err_o,
  input  logic [N_REQ-1:0]     rsp_ready_i,
  output logic                 sq_enb_o,
  output logic [7:0]           sq_dt_o,
  input  logic                 sq_busy_i,
  input  logic [7:0]           sq_dt_i,
  output logic [ID_W-1:0]      grant_id_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [7:0]       op_q, op_d;
  logic [7:0]       res_q, res_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic             enb_q, enb_d;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [7:0]       win_data;
  logic [N_REQ-1:0] grant_oh;

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // Round-robin search: first valid requester after the last owner, wrapping.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx  = (int'(last_id_q) + i) % N_REQ;
      cand = ID_W'(idx);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_id == ID_W'(k)) begin
        win_data = req_data_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    grant_d     = grant_q;
    op_d        = op_q;
    res_d       = res_q;
    rsp_valid_d = rsp_valid_q;
    enb_d       = enb_q;
    req_ready_o = '0;
`ifdef SQRT_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready_o[win_id] = 1'b1;
          grant_d             = win_id;
          op_d                = win_data;
          enb_d               = 1'b1;
          state_d             = S_LAUNCH;
`ifdef SQRT_ARB_TIMEOUT_EN
          // Down-counter terminates at zero, so load limit-1.
          tmo_d               = TMO_W'(TIMEOUT_CYC - 1);
`endif
        end
      end
      S_LAUNCH: begin
        if (sq_busy_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!sq_busy_i) begin
          res_d       = sq_dt_i;
          enb_d       = 1'b0;
          rsp_valid_d = grant_oh;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        // Only the owner's ready matters; the sqrt stays frozen until then.
        if (rsp_ready_i[grant_q]) begin
          rsp_valid_d = '0;
          last_id_d   = grant_q;
          state_d     = S_IDLE;
`ifdef SQRT_ARB_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef SQRT_ARB_TIMEOUT_EN
    // Watchdog overrides LAUNCH/RUN progress unless RUN completes normally
    // this cycle.
    if (state_q == S_LAUNCH || (state_q == S_RUN && sq_busy_i)) begin
      if (tmo_q == '0) begin
        res_d       = '0;
        err_d       = 1'b1;
        enb_d       = 1'b0;
        rsp_valid_d = grant_oh;
        state_d     = S_RESP;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      last_id_q   <= ID_W'(N_REQ - 1);
      grant_q     <= '0;
      op_q        <= '0;
      res_q       <= '0;
      rsp_valid_q <= '0;
      enb_q       <= 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      res_q       <= res_d;
      rsp_valid_q <= rsp_valid_d;
      enb_q       <= enb_d;
`ifdef SQRT_ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  assign sq_enb_o    = enb_q;
  assign sq_dt_o     = op_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = res_q;
  assign grant_id_o  = grant_q;

`ifdef SQRT_ARB_TIMEOUT_EN
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule
